regfile_wb_arbiter: RTL and testbench

- Owns the single register-file write port; shares it between the in-order pipeline writeback stage (WB) and a long-latency unit (LL: mul/div, syscall return).
- Buffers LL results in a small FIFO when WB holds the port.
- Keeps a 32-entry busy scoreboard of LL destinations so decode can stall on RAW/WAW hazards.
- Sits between the WB stage / LL unit and the register file write inputs (rd, write_data, sig_reg_write).

---
 rtl/regfile_wb_arbiter.sv | 213 +++++++++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter between writeback (WB) and a long-latency unit (LL),
// with an LL result FIFO and a busy scoreboard. Optional trace output: define REGARB_TRACE_EN.
module regfile_wb_arbiter #(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        wb_stall,
  input  logic        ll_valid,
  input  logic [4:0]  ll_rd,
  input  logic [31:0] ll_data,
  output logic        ll_ready,
  input  logic        iss_valid,
  input  logic [4:0]  iss_rd,
  input  logic [4:0]  dec_rs,
  input  logic [4:0]  dec_rt,
  input  logic [4:0]  dec_rd,
  output logic        dec_hazard,
  output logic        rf_we,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_wdata,
  output logic [31:0] busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SW    = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(FIFO_DEPTH);
  localparam logic [SW-1:0]    STARVE_MAX = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_WB   = 2'd1,
    SRC_FIFO = 2'd2,
    SRC_BYP  = 2'd3
  } src_e;

  logic [4:0]       mem_rd_q   [FIFO_DEPTH];
  logic [31:0]      mem_data_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [SW-1:0]    starve_q, starve_d;
  logic [31:0]      busy_q, busy_d;
  logic             rf_we_q, rf_we_d;
  logic [4:0]       rf_rd_q, rf_rd_d;
  logic [31:0]      rf_wdata_q, rf_wdata_d;

  src_e        src_s;
  logic [4:0]  win_rd_s;
  logic [31:0] win_data_s;
  logic        fifo_empty_s;
  logic        fifo_full_s;
  logic        stall_s;
  logic        enq_s;
  logic        deq_s;

  assign fifo_empty_s = (count_q == {CNT_W{1'b0}});
  assign fifo_full_s  = (count_q == DEPTH_C);
  assign stall_s      = (starve_q == STARVE_MAX);

  assign wb_stall = stall_s;
  assign ll_ready = !fifo_full_s;
  assign rf_we    = rf_we_q;
  assign rf_rd    = rf_rd_q;
  assign rf_wdata = rf_wdata_q;
  assign busy     = busy_q;

  assign dec_hazard = ((dec_rs != 5'd0) && busy_q[dec_rs]) ||
                      ((dec_rt != 5'd0) && busy_q[dec_rt]) ||
                      ((dec_rd != 5'd0) && busy_q[dec_rd]);

  // Grant selection: starvation relief, then WB, then FIFO head, then LL bypass
  always_comb begin
    src_s      = SRC_NONE;
    win_rd_s   = 5'd0;
    win_data_s = 32'd0;
    if (stall_s && !fifo_empty_s) begin
      src_s = SRC_FIFO;
    end else if (wb_valid) begin
      src_s = SRC_WB;
    end else if (!fifo_empty_s) begin
      src_s = SRC_FIFO;
    end else if (ll_valid) begin
      src_s = SRC_BYP;
    end else begin
      src_s = SRC_NONE;
    end
    case (src_s)
      SRC_WB: begin
        win_rd_s   = wb_rd;
        win_data_s = wb_data;
      end
      SRC_FIFO: begin
        win_rd_s   = mem_rd_q[rd_ptr_q];
        win_data_s = mem_data_q[rd_ptr_q];
      end
      SRC_BYP: begin
        win_rd_s   = ll_rd;
        win_data_s = ll_data;
      end
      default: begin
        win_rd_s   = 5'd0;
        win_data_s = 32'd0;
      end
    endcase
  end

  assign enq_s = ll_valid && !fifo_full_s && (src_s != SRC_BYP);
  assign deq_s = (src_s == SRC_FIFO);

  // Next-state for FIFO bookkeeping, starve counter, scoreboard and write port
  always_comb begin
    wr_ptr_d = enq_s ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
    rd_ptr_d = deq_s ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
    case ({enq_s, deq_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (!fifo_empty_s && (src_s == SRC_WB)) begin
      starve_d = stall_s ? STARVE_MAX : (starve_q + SW'(1));
    end else begin
      starve_d = {SW{1'b0}};
    end

    // Set is applied after clear so a same-cycle reissue stays outstanding
    busy_d = busy_q;
    if ((src_s == SRC_FIFO) || (src_s == SRC_BYP)) begin
      busy_d[win_rd_s] = 1'b0;
    end else begin
      busy_d = busy_q;
    end
    if (iss_valid && (iss_rd != 5'd0)) begin
      busy_d[iss_rd] = 1'b1;
    end else begin
      busy_d[0] = 1'b0;
    end
    busy_d[0] = 1'b0;

    rf_we_d = (src_s != SRC_NONE) && (win_rd_s != 5'd0);
    if (src_s != SRC_NONE) begin
      rf_rd_d    = win_rd_s;
      rf_wdata_d = win_data_s;
    end else begin
      rf_rd_d    = rf_rd_q;
      rf_wdata_d = rf_wdata_q;
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_rd_q[i]   <= 5'd0;
        mem_data_q[i] <= 32'd0;
      end
    end else if (enq_s) begin
      mem_rd_q[wr_ptr_q]   <= ll_rd;
      mem_data_q[wr_ptr_q] <= ll_data;
    end
  end

  // Control state and registered write port
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= {PTR_W{1'b0}};
      rd_ptr_q   <= {PTR_W{1'b0}};
      count_q    <= {CNT_W{1'b0}};
      starve_q   <= {SW{1'b0}};
      busy_q     <= 32'd0;
      rf_we_q    <= 1'b0;
      rf_rd_q    <= 5'd0;
      rf_wdata_q <= 32'd0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      starve_q   <= starve_d;
      busy_q     <= busy_d;
      rf_we_q    <= rf_we_d;
      rf_rd_q    <= rf_rd_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

`ifdef REGARB_TRACE_EN
  logic [31:0] cycle_q;
  src_e        trc_src_q;

  // Trace each committed register-file write with its source
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q   <= 32'd0;
      trc_src_q <= SRC_NONE;
    end else begin
      cycle_q   <= cycle_q + 32'd1;
      trc_src_q <= src_s;
      if (rf_we_q) begin
        $display("regarb cyc=%0d src=%s rd=%0d data=%08h", cycle_q,
                 (trc_src_q == SRC_WB) ? "WB" : ((trc_src_q == SRC_FIFO) ? "LL" : "BYP"),
                 rf_rd_q, rf_wdata_q);
      end
    end
  end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter (FIFO_DEPTH=2, STARVE_LIMIT=4).
module tb_regfile_wb_arbiter;
  logic        clk;
  logic        rst;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_stall;
  logic        ll_valid;
  logic [4:0]  ll_rd;
  logic [31:0] ll_data;
  logic        ll_ready;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic [4:0]  dec_rs, dec_rt, dec_rd;
  logic        dec_hazard;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;
  logic [31:0] busy;

  int total = 0;
  int bad   = 0;

  regfile_wb_arbiter #(.FIFO_DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_stall(wb_stall),
    .ll_valid(ll_valid), .ll_rd(ll_rd), .ll_data(ll_data), .ll_ready(ll_ready),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .dec_rs(dec_rs), .dec_rt(dec_rt), .dec_rd(dec_rd), .dec_hazard(dec_hazard),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb_valid = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
    ll_valid = 1'b0; ll_rd = 5'd0; ll_data = 32'd0;
    iss_valid = 1'b0; iss_rd = 5'd0;
    dec_rs = 5'd0; dec_rt = 5'd0; dec_rd = 5'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    tick();
    tick();
    rst = 1'b0;
    total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL reset_rf_we got=%b exp=0", rf_we); end
    total++; if (rf_rd !== 5'd0) begin bad++; $display("FAIL reset_rf_rd got=%0d exp=0", rf_rd); end
    total++; if (rf_wdata !== 32'd0) begin bad++; $display("FAIL reset_rf_wdata got=%h exp=0", rf_wdata); end
    total++; if (busy !== 32'd0) begin bad++; $display("FAIL reset_busy got=%h exp=0", busy); end
    total++; if (ll_ready !== 1'b1) begin bad++; $display("FAIL reset_ll_ready got=%b exp=1", ll_ready); end
    total++; if (wb_stall !== 1'b0) begin bad++; $display("FAIL reset_wb_stall got=%b exp=0", wb_stall); end
    tick();
    total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL idle_rf_we got=%b exp=0", rf_we); end
  endtask

  task automatic test_wb_only();
    wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'h0000_1234;
    tick();
    idle();
    total++; if (rf_we !== 1'b1) begin bad++; $display("FAIL wb_only_we got=%b exp=1", rf_we); end
    total++; if (rf_rd !== 5'd5) begin bad++; $display("FAIL wb_only_rd got=%0d exp=5", rf_rd); end
    total++; if (rf_wdata !== 32'h0000_1234) begin bad++; $display("FAIL wb_only_data got=%h exp=00001234", rf_wdata); end
    tick();
    total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL wb_only_after got=%b exp=0", rf_we); end
  endtask

  task automatic test_collision();
    iss_valid = 1'b1; iss_rd = 5'd8;
    tick();
    idle();
    total++; if (busy !== 32'h0000_0100) begin bad++; $display("FAIL coll_busy_set got=%h exp=00000100", busy); end
    wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h0000_0033;
    ll_valid = 1'b1; ll_rd = 5'd8; ll_data = 32'h0000_00AA;
    tick();
    idle();
    total++; if (rf_we !== 1'b1 || rf_rd !== 5'd3 || rf_wdata !== 32'h33) begin
      bad++; $display("FAIL coll_wb_first got=%b/%0d/%h exp=1/3/00000033", rf_we, rf_rd, rf_wdata); end
    total++; if (busy[8] !== 1'b1) begin bad++; $display("FAIL coll_busy_held got=%b exp=1", busy[8]); end
    total++; if (ll_ready !== 1'b1) begin bad++; $display("FAIL coll_ll_ready got=%b exp=1", ll_ready); end
    tick();
    total++; if (rf_we !== 1'b1 || rf_rd !== 5'd8 || rf_wdata !== 32'hAA) begin
      bad++; $display("FAIL coll_ll_second got=%b/%0d/%h exp=1/8/000000aa", rf_we, rf_rd, rf_wdata); end
    total++; if (busy !== 32'd0) begin bad++; $display("FAIL coll_busy_clr got=%h exp=0", busy); end
    tick();
    total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL coll_idle got=%b exp=0", rf_we); end
  endtask

  task automatic test_starvation();
    wb_valid = 1'b1; wb_rd = 5'd1; wb_data = 32'h100;
    ll_valid = 1'b1; ll_rd = 5'd10; ll_data = 32'hBB;
    tick();
    ll_valid = 1'b0; ll_rd = 5'd0; ll_data = 32'd0;
    total++; if (rf_wdata !== 32'h100) begin bad++; $display("FAIL starve_first got=%h exp=00000100", rf_wdata); end
    for (int i = 1; i <= 4; i++) begin
      wb_data = 32'h100 + 32'(i);
      total++; if (wb_stall !== 1'b0) begin bad++; $display("FAIL starve_nostall_%0d got=%b exp=0", i, wb_stall); end
      tick();
      total++; if (rf_rd !== 5'd1 || rf_wdata !== 32'h100 + 32'(i)) begin
        bad++; $display("FAIL starve_wb_%0d got=%0d/%h exp=1/%h", i, rf_rd, rf_wdata, 32'h100 + 32'(i)); end
    end
    wb_data = 32'h105;
    total++; if (wb_stall !== 1'b1) begin bad++; $display("FAIL starve_stall got=%b exp=1", wb_stall); end
    tick();
    total++; if (rf_we !== 1'b1 || rf_rd !== 5'd10 || rf_wdata !== 32'hBB) begin
      bad++; $display("FAIL starve_fifo got=%b/%0d/%h exp=1/10/000000bb", rf_we, rf_rd, rf_wdata); end
    total++; if (wb_stall !== 1'b0) begin bad++; $display("FAIL starve_stall_once got=%b exp=0", wb_stall); end
    tick();
    idle();
    total++; if (rf_rd !== 5'd1 || rf_wdata !== 32'h105) begin
      bad++; $display("FAIL starve_wb_resume got=%0d/%h exp=1/00000105", rf_rd, rf_wdata); end
    tick();
  endtask

  task automatic test_full();
    wb_valid = 1'b1; wb_rd = 5'd2; wb_data = 32'h21;
    ll_valid = 1'b1; ll_rd = 5'd11; ll_data = 32'hC1;
    tick();
    total++; if (ll_ready !== 1'b1) begin bad++; $display("FAIL full_ready1 got=%b exp=1", ll_ready); end
    wb_data = 32'h22; ll_rd = 5'd12; ll_data = 32'hC2;
    tick();
    total++; if (rf_wdata !== 32'h22) begin bad++; $display("FAIL full_wb got=%h exp=00000022", rf_wdata); end
    total++; if (ll_ready !== 1'b0) begin bad++; $display("FAIL full_not_ready got=%b exp=0", ll_ready); end
    wb_valid = 1'b0; ll_rd = 5'd13; ll_data = 32'hC3;
    tick();
    total++; if (rf_rd !== 5'd11 || rf_wdata !== 32'hC1) begin
      bad++; $display("FAIL full_drain1 got=%0d/%h exp=11/000000c1", rf_rd, rf_wdata); end
    total++; if (ll_ready !== 1'b1) begin bad++; $display("FAIL full_ready_again got=%b exp=1", ll_ready); end
    tick();
    idle();
    total++; if (rf_rd !== 5'd12 || rf_wdata !== 32'hC2) begin
      bad++; $display("FAIL full_drain2 got=%0d/%h exp=12/000000c2", rf_rd, rf_wdata); end
    tick();
    total++; if (rf_we !== 1'b1 || rf_rd !== 5'd13 || rf_wdata !== 32'hC3) begin
      bad++; $display("FAIL full_third got=%b/%0d/%h exp=1/13/000000c3", rf_we, rf_rd, rf_wdata); end
    tick();
    total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL full_empty got=%b exp=0", rf_we); end
  endtask

  task automatic test_scoreboard();
    iss_valid = 1'b1; iss_rd = 5'd9;
    tick();
    iss_valid = 1'b0; iss_rd = 5'd0;
    dec_rt = 5'd9;
    #1;
    total++; if (dec_hazard !== 1'b1) begin bad++; $display("FAIL sb_hazard got=%b exp=1", dec_hazard); end
    total++; if (busy !== 32'h0000_0200) begin bad++; $display("FAIL sb_busy got=%h exp=00000200", busy); end
    dec_rt = 5'd4; dec_rs = 5'd0; dec_rd = 5'd0;
    #1;
    total++; if (dec_hazard !== 1'b0) begin bad++; $display("FAIL sb_nohazard got=%b exp=0", dec_hazard); end
    dec_rt = 5'd0; dec_rd = 5'd9;
    wb_valid = 1'b1; wb_rd = 5'd9; wb_data = 32'h99;
    tick();
    wb_valid = 1'b0;
    total++; if (rf_rd !== 5'd9 || rf_wdata !== 32'h99 || busy[9] !== 1'b1) begin
      bad++; $display("FAIL sb_wb_busy got=%0d/%h/%b exp=9/00000099/1", rf_rd, rf_wdata, busy[9]); end
    ll_valid = 1'b1; ll_rd = 5'd9; ll_data = 32'h9A;
    iss_valid = 1'b1; iss_rd = 5'd9;
    tick();
    iss_valid = 1'b0; ll_data = 32'h9B;
    total++; if (rf_we !== 1'b1 || rf_rd !== 5'd9 || rf_wdata !== 32'h9A) begin
      bad++; $display("FAIL sb_bypass got=%b/%0d/%h exp=1/9/0000009a", rf_we, rf_rd, rf_wdata); end
    total++; if (busy[9] !== 1'b1 || dec_hazard !== 1'b1) begin
      bad++; $display("FAIL sb_set_wins got=%b/%b exp=1/1", busy[9], dec_hazard); end
    tick();
    ll_valid = 1'b0;
    total++; if (rf_wdata !== 32'h9B || busy !== 32'd0 || dec_hazard !== 1'b0) begin
      bad++; $display("FAIL sb_commit got=%h/%h/%b exp=0000009b/00000000/0", rf_wdata, busy, dec_hazard); end
    idle();
    wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'hDEAD;
    iss_valid = 1'b1; iss_rd = 5'd0;
    tick();
    idle();
    total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL sb_r0_wb got=%b exp=0", rf_we); end
    total++; if (busy !== 32'd0) begin bad++; $display("FAIL sb_r0_iss got=%h exp=0", busy); end
    ll_valid = 1'b1; ll_rd = 5'd0; ll_data = 32'hBEEF;
    tick();
    idle();
    total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL sb_r0_ll got=%b exp=0", rf_we); end
    tick();
  endtask

  task automatic test_mid_reset();
    wb_valid = 1'b1; wb_rd = 5'd6; wb_data = 32'h66;
    ll_valid = 1'b1; ll_rd = 5'd7; ll_data = 32'h77;
    iss_valid = 1'b1; iss_rd = 5'd7;
    tick();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (busy !== 32'd0 || ll_ready !== 1'b1 || rf_we !== 1'b0) begin
      bad++; $display("FAIL midrst_state got=%h/%b/%b exp=00000000/1/0", busy, ll_ready, rf_we); end
    tick();
    total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL midrst_fifo_discard got=%b exp=0", rf_we); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      wb_valid = 1'b1; wb_rd = 5'(i + 20); wb_data = 32'hA000 + 32'(i);
      tick();
      total++; if (rf_we !== 1'b1 || rf_rd !== 5'(i + 20) || rf_wdata !== 32'hA000 + 32'(i)) begin
        bad++; $display("FAIL b2b_%0d got=%b/%0d/%h exp=1/%0d/%h", i, rf_we, rf_rd, rf_wdata, i + 20, 32'hA000 + 32'(i)); end
    end
    idle();
    tick();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_wb_only();
    test_collision();
    test_starvation();
    test_full();
    test_scoreboard();
    test_mid_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
